// File: rtl/rgmii_tx_nibble_gen.sv
// rgmii_tx_nibble_gen
// Converts a byte-wide GMII transmit stream into per-cycle rising/falling
// edge values for the RGMII TXD[3:0], TX_CTL and TXC pins. The values feed a
// DDR output stage. The block runs from a single 125 MHz clock at all speeds.
//   1000 Mb/s : one byte per cycle, TXD carries the low nibble on the rising
//               edge and the high nibble on the falling edge.
//   100 Mb/s  : nibble period 5 cycles, one byte every 10 cycles.
//   10 Mb/s   : nibble period 50 cycles, one byte every 100 cycles.
// Ports:
//   clk          125 MHz transmit clock
//   rst_n        asynchronous reset, active-low
//   gmii_txd     transmit byte, sampled when gmii_clk_en=1
//   gmii_tx_en   transmit enable, sampled with gmii_txd
//   gmii_tx_er   transmit error, sampled with gmii_txd
//   speed        2'b10/2'b11=1000, 2'b01=100, 2'b00=10, sampled with gmii_txd
//   gmii_clk_en  byte strobe to the MAC (registered)
//   txd_d1/d2    TXD nibble for the rising/falling edge
//   txctl_d1/d2  TX_CTL for the rising/falling edge (tx_en, tx_en^tx_er)
//   txc_d1/d2    TXC pattern bit for the rising/falling edge
module rgmii_tx_nibble_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] gmii_txd,
   input  logic       gmii_tx_en,
   input  logic       gmii_tx_er,
   input  logic [1:0] speed,
   output logic       gmii_clk_en,
   output logic [3:0] txd_d1,
   output logic [3:0] txd_d2,
   output logic       txctl_d1,
   output logic       txctl_d2,
   output logic       txc_d1,
   output logic       txc_d2
);

   localparam logic [1:0] SPD_10   = 2'b00;
   localparam logic [1:0] SPD_100  = 2'b01;
   localparam logic [1:0] SPD_1000 = 2'b10;
   localparam logic [5:0] LAST_100 = 6'd4;
   localparam logic [5:0] LAST_10  = 6'd49;

   logic [5:0] cnt;
   logic       ph;
   logic [1:0] mode;
   logic [3:0] hi;

   logic [1:0] spd_in;
   logic [5:0] last;
   logic [5:0] cnt_nx;
   logic       ph_nx;

   // TXC {rising, falling} bit for nibble position p. In 100 mode the clock is
   // high for 2.5 of the 5 cycles, so position 2 splits across the edges.
   function automatic logic [1:0] txc_pattern(input logic [1:0] m, input logic [5:0] p);
      logic [1:0] pat;
      if (m == SPD_100) begin
         if (p < 6'd2)       pat = 2'b11;
         else if (p == 6'd2) pat = 2'b10;
         else                pat = 2'b00;
      end else if (m == SPD_10) begin
         pat = (p < 6'd25) ? 2'b11 : 2'b00;
      end else begin
         pat = 2'b10;
      end
      return pat;
   endfunction

   always_comb begin
      // 2'b11 is folded into 1000 so that mode holds only three legal values.
      spd_in = (speed == 2'b11) ? SPD_1000 : speed;
      last   = (mode == SPD_10) ? LAST_10 : LAST_100;
      if (cnt == last) begin
         cnt_nx = 6'd0;
         ph_nx  = 1'b1;
      end else begin
         cnt_nx = cnt + 6'd1;
         ph_nx  = ph;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 6'd0;
         ph          <= 1'b0;
         mode        <= SPD_1000;
         hi          <= 4'd0;
         gmii_clk_en <= 1'b1;
         txd_d1      <= 4'd0;
         txd_d2      <= 4'd0;
         txctl_d1    <= 1'b0;
         txctl_d2    <= 1'b0;
         txc_d1      <= 1'b0;
         txc_d2      <= 1'b0;
      end else if (gmii_clk_en) begin
         // Sampling edge: a new byte period starts at position 0 of the low nibble.
         mode     <= spd_in;
         hi       <= gmii_txd[7:4];
         cnt      <= 6'd0;
         ph       <= 1'b0;
         txd_d1   <= gmii_txd[3:0];
         txctl_d1 <= gmii_tx_en;
         txctl_d2 <= gmii_tx_en ^ gmii_tx_er;
         {txc_d1, txc_d2} <= txc_pattern(spd_in, 6'd0);
         if (spd_in == SPD_1000) begin
            txd_d2      <= gmii_txd[7:4];
            gmii_clk_en <= 1'b1;
         end else begin
            txd_d2      <= gmii_txd[3:0];
            gmii_clk_en <= 1'b0;
         end
      end else begin
         // Only 10/100 mode gets here; 1000 mode keeps gmii_clk_en high.
         cnt <= cnt_nx;
         ph  <= ph_nx;
         {txc_d1, txc_d2} <= txc_pattern(mode, cnt_nx);
         if (ph_nx) begin
            txd_d1 <= hi;
            txd_d2 <= hi;
         end
         // Strobe is registered, so it is raised when entering the final cycle.
         gmii_clk_en <= ph_nx && (cnt_nx == last);
      end
   end

endmodule

// File: tb/tb_rgmii_tx_nibble_gen.sv
`timescale 1ns/1ps
module tb_rgmii_tx_nibble_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] gmii_txd = 8'h00;
   logic       gmii_tx_en = 1'b0;
   logic       gmii_tx_er = 1'b0;
   logic [1:0] speed = 2'b10;
   logic       gmii_clk_en;
   logic [3:0] txd_d1, txd_d2;
   logic       txctl_d1, txctl_d2, txc_d1, txc_d2;

   int errors = 0;
   int checks = 0;

   rgmii_tx_nibble_gen dut (
      .clk(clk), .rst_n(rst_n), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
      .gmii_tx_er(gmii_tx_er), .speed(speed), .gmii_clk_en(gmii_clk_en),
      .txd_d1(txd_d1), .txd_d2(txd_d2), .txctl_d1(txctl_d1), .txctl_d2(txctl_d2),
      .txc_d1(txc_d1), .txc_d2(txc_d2)
   );

   always #4 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte-level reference model: which byte is in flight, its speed, and
   // the cycle index k within its byte period (0 .. 2N-1).
   logic       m_rst = 1'b1;
   logic [7:0] m_byte = 8'h00;
   logic       m_en = 1'b0, m_er = 1'b0;
   logic [1:0] m_spd = 2'b10;
   int         m_k = 0;

   function automatic int period_n(input logic [1:0] s);
      if (s == 2'b01) return 5;
      if (s == 2'b00) return 50;
      return 0;
   endfunction

   function automatic logic model_clk_en();
      int n;
      n = period_n(m_spd);
      return m_rst || (n == 0) || (m_k == 2 * n - 1);
   endfunction

   // {clk_en, txd_d1, txd_d2, txc_d1, txc_d2, txctl_d1, txctl_d2}
   function automatic logic [12:0] model_out();
      int n, p;
      logic [3:0] nib;
      if (m_rst) return 13'h1000;
      n = period_n(m_spd);
      if (n == 0) return {1'b1, m_byte[3:0], m_byte[7:4], 2'b10, m_en, m_en ^ m_er};
      nib = (m_k < n) ? m_byte[3:0] : m_byte[7:4];
      p = m_k % n;
      // TXC is high for the first half of the nibble period, counted in half-cycles.
      return {m_k == 2 * n - 1, nib, nib, 2 * p < n, 2 * p + 1 < n, m_en, m_en ^ m_er};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rst <= 1'b1;
         m_k   <= 0;
      end else if (model_clk_en()) begin
         m_rst  <= 1'b0;
         m_byte <= gmii_txd;
         m_en   <= gmii_tx_en;
         m_er   <= gmii_tx_er;
         m_spd  <= speed;
         m_k    <= 0;
      end else begin
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk) begin
      chk("cycle_model",
          32'({gmii_clk_en, txd_d1, txd_d2, txc_d1, txc_d2, txctl_d1, txctl_d2}),
          32'(model_out()));
   end

   task automatic wait_pulse(output int c);
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (gmii_clk_en !== 1'b1 && c < 300);
   endtask

   logic [1:0] pat100 [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};

   initial begin
      int c;
      gmii_txd = 8'h5A; gmii_tx_en = 1'b1; gmii_tx_er = 1'b0; speed = 2'b10;
      repeat (3) @(negedge clk);
      chk("reset_txd", 32'({txd_d1, txd_d2}), 32'h00);
      chk("reset_txc_txctl", 32'({txc_d1, txc_d2, txctl_d1, txctl_d2}), 32'h0);
      chk("reset_clk_en", 32'(gmii_clk_en), 32'h1);
      rst_n = 1'b1;

      // 1000 mode, two consecutive bytes
      @(posedge clk); #1;
      chk("g_byte0_txd", 32'({txd_d1, txd_d2}), 32'hA5);
      chk("g_byte0_txc", 32'({txc_d1, txc_d2}), 32'h2);
      @(negedge clk); gmii_txd = 8'hC3;
      @(posedge clk); #1;
      chk("g_byte1_txd", 32'({txd_d1, txd_d2}), 32'h3C);
      chk("g_clk_en", 32'(gmii_clk_en), 32'h1);

      // TX_CTL encodings
      @(negedge clk); gmii_tx_er = 1'b1;
      @(posedge clk); #1;
      chk("txctl_en_er", 32'({txctl_d1, txctl_d2}), 32'h2);
      @(negedge clk); gmii_tx_en = 1'b0;
      @(posedge clk); #1;
      chk("txctl_er_only", 32'({txctl_d1, txctl_d2}), 32'h1);

      // 100 mode, byte 0x5A over 10 cycles
      @(negedge clk); gmii_tx_en = 1'b1; gmii_tx_er = 1'b0; gmii_txd = 8'h5A; speed = 2'b01;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("m100_txd", 32'({txd_d1, txd_d2}), (i < 5) ? 32'hAA : 32'h55);
         chk("m100_txc", 32'({txc_d1, txc_d2}), 32'(pat100[i % 5]));
         chk("m100_clk_en", 32'(gmii_clk_en), (i == 9) ? 32'h1 : 32'h0);
         chk("m100_txctl", 32'({txctl_d1, txctl_d2}), 32'h3);
      end

      // speed switched to 1000 in the middle of a 100 byte
      gmii_txd = 8'h96;
      @(posedge clk); #1;
      c = 0;
      while (gmii_clk_en !== 1'b1 && c < 30) begin
         if (c == 2) speed = 2'b10;
         @(posedge clk); #1;
         c++;
      end
      chk("spd_chg_byte_len", 32'(c), 32'd9);
      for (int i = 0; i < 5; i++) begin
         gmii_txd = 8'(i * 37 + 5);
         @(posedge clk); #1;
         chk("spd_chg_clk_en", 32'(gmii_clk_en), 32'h1);
         chk("spd_chg_txc", 32'({txc_d1, txc_d2}), 32'h2);
      end

      // reset in cycle 7 of a 100 byte
      speed = 2'b01; gmii_txd = 8'hE7;
      @(posedge clk); #1;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", 32'({txd_d1, txd_d2, txc_d1, txc_d2, txctl_d1, txctl_d2}), 32'h0);
      chk("mid_rst_clk_en", 32'(gmii_clk_en), 32'h1);
      @(negedge clk); rst_n = 1'b1; gmii_txd = 8'h4B;
      @(posedge clk); #1;
      chk("post_rst_txd", 32'({txd_d1, txd_d2}), 32'hBB);
      chk("post_rst_txc", 32'({txc_d1, txc_d2}), 32'h3);

      // 10 mode, stream of 4 bytes
      speed = 2'b00;
      wait_pulse(c);
      for (int b = 0; b < 4; b++) begin
         gmii_txd = 8'($urandom);
         wait_pulse(c);
         chk("m10_spacing", 32'(c), 32'd100);
      end

      // randomized traffic, speed changing freely between sampling edges
      repeat (4000) begin
         @(negedge clk);
         gmii_txd   = 8'($urandom);
         gmii_tx_en = 1'($urandom);
         gmii_tx_er = 1'($urandom_range(0, 3) == 0);
         speed      = 2'($urandom);
      end
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
